piece_collision_scanner: RTL

//  Sequential initiator for the piece-shape lookup. Given a candidate piece (type, rotation, origin),
//  it walks the piece's 4x4 shape grid, reads the playfield occupancy RAM for every active cell,
//  and reports collision / out-of-bounds. Sits between the game-control FSM (move/rotate/spawn

---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/piece_shape_rom.sv | 26 ++
 rtl/piece_collision_scanner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tetris_pkg                                                       |
// | Purpose : Shared board geometry defaults, piece-type codes, the 4x4 piece  |
// |           shape table and the scanner FSM state encoding.                  |
// | Shape mask: bit (15-idx) is the cell at row idx[3:2], col idx[1:0],        |
// |           row 0 at the top. Rotations step clockwise.                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  localparam logic [2:0] PIECE_I    = 3'd0;
  localparam logic [2:0] PIECE_J    = 3'd1;
  localparam logic [2:0] PIECE_L    = 3'd2;
  localparam logic [2:0] PIECE_O    = 3'd3;
  localparam logic [2:0] PIECE_S    = 3'd4;
  localparam logic [2:0] PIECE_T    = 3'd5;
  localparam logic [2:0] PIECE_Z    = 3'd6;
  localparam logic [2:0] PIECE_NONE = 3'd7;

  // [type][rot]; PIECE_NONE has no row and maps to an empty mask in the ROM.
  localparam logic [15:0] SHAPE_TABLE [7][4] = '{
    '{16'h0F00, 16'h2222, 16'h00F0, 16'h4444},  // I
    '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},  // J
    '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440},  // L
    '{16'h6600, 16'h6600, 16'h6600, 16'h6600},  // O
    '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},  // S
    '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},  // T
    '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80}   // Z
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/piece_shape_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : piece_shape_rom                                                  |
// | Purpose : Combinational (piece type, rotation) -> 16-bit 4x4 shape mask.   |
// | Ports   : piece_type [2:0] in  piece code, 7 = no piece                    |
// |           rot        [1:0] in  rotation 0..3                               |
// |           mask      [15:0] out shape mask, 0 for no piece                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module piece_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0]  piece_type,
  input  logic [1:0]  rot,
  output logic [15:0] mask
);

  always_comb begin
    mask = '0;
    if (piece_type != PIECE_NONE) begin
      mask = SHAPE_TABLE[piece_type][rot];
    end
  end

endmodule
`default_nettype wire

// File: rtl/piece_collision_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : piece_collision_scanner                                          |
// | Purpose : Walks a candidate piece's 4x4 shape grid one cell per clock,     |
// |           reads board occupancy for each in-board active cell and reports |
// |           collision / out-of-bounds with a fixed response latency.         |
// | Ports   : clk, rst_n (async, active low)                                   |
// |           req_valid/req_ready, req_type[2:0], req_rot[1:0],                |
// |           req_x[4:0] (signed), req_y[5:0] (signed)  - check request        |
// |           brd_rd_en, brd_rd_x[3:0], brd_rd_y[4:0], brd_rd_data - board RAM |
// |           rsp_valid/rsp_ready, rsp_collide, rsp_oob  - result              |
// |           rsp_cells[35:0] (only with PIECE_CELLS_OUT_EN) - active cell     |
// |           coordinates {x[3:0],y[4:0]} in scan order, cell0 in [8:0]        |
// | Config  : define PIECE_CELLS_OUT_EN to add the rsp_cells port.             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module piece_collision_scanner
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [1:0]  req_rot,
  input  logic [4:0]  req_x,
  input  logic [5:0]  req_y,
  output logic        brd_rd_en,
  output logic [3:0]  brd_rd_x,
  output logic [4:0]  brd_rd_y,
  input  logic        brd_rd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_collide,
  output logic        rsp_oob
`ifdef PIECE_CELLS_OUT_EN
  ,
  output logic [35:0] rsp_cells
`endif
);

  localparam logic [6:0] LIM_X = 7'(BOARD_W);
  localparam logic [6:0] LIM_Y = 7'(BOARD_H);

  scan_state_t state_q, state_d;
  logic [3:0]  idx_q;
  logic [2:0]  type_q;
  logic [1:0]  rot_q;
  logic [4:0]  x_q;
  logic [5:0]  y_q;
  logic        collide_q, oob_q, rd_pend_q;

  logic [15:0] mask;
  logic [6:0]  ax, ay;
  logic        accept, cell_active, cell_oob, cell_read;

  piece_shape_rom u_rom (
    .piece_type (type_q),
    .rot        (rot_q),
    .mask       (mask)
  );

  // 7-bit signed sums: wide enough that -16+3 and 31+3 never wrap.
  assign ax = {{2{x_q[4]}}, x_q} + {5'd0, idx_q[1:0]};
  assign ay = {y_q[5], y_q}      + {5'd0, idx_q[3:2]};

  assign cell_active = (state_q == ST_SCAN) && mask[4'd15 - idx_q];
  // Bit 6 is the sign; upper-limit compares only apply to non-negative values.
  assign cell_oob    = cell_active &&
                       (ax[6] || (ax >= LIM_X) || (!ay[6] && (ay >= LIM_Y)));
  // Cells above the board (ay<0) are legal spawn-zone cells and need no read.
  assign cell_read   = cell_active && !cell_oob && !ay[6];

  assign req_ready   = rst_n && (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;

  assign brd_rd_en   = cell_read;
  assign brd_rd_x    = cell_read ? ax[3:0] : 4'd0;
  assign brd_rd_y    = cell_read ? ay[4:0] : 5'd0;

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_collide = rsp_valid && collide_q;
  assign rsp_oob     = rsp_valid && oob_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SCAN;
      ST_SCAN:  if (idx_q == 4'd15) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      type_q    <= 3'd0;
      rot_q     <= 2'd0;
      x_q       <= 5'd0;
      y_q       <= 6'd0;
      collide_q <= 1'b0;
      oob_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= cell_read;
      if (accept) begin
        type_q    <= req_type;
        rot_q     <= req_rot;
        x_q       <= req_x;
        y_q       <= req_y;
        idx_q     <= 4'd0;
        collide_q <= 1'b0;
        oob_q     <= 1'b0;
      end
      if (state_q == ST_SCAN) idx_q <= idx_q + 4'd1;
      if (cell_oob) oob_q <= 1'b1;
      // Read data lands one cycle after the strobe; DRAIN covers the idx15 read.
      if (rd_pend_q && brd_rd_data) collide_q <= 1'b1;
    end
  end

`ifdef PIECE_CELLS_OUT_EN
  logic [2:0]  cell_cnt_q;
  logic [35:0] cells_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_cnt_q <= 3'd0;
      cells_q    <= '0;
    end else if (accept) begin
      cell_cnt_q <= 3'd0;
      cells_q    <= '0;
    end else if (cell_active) begin
      for (int k = 0; k < 4; k++) begin
        if (cell_cnt_q == 3'(k)) cells_q[k*9 +: 9] <= {ax[3:0], ay[4:0]};
      end
      cell_cnt_q <= cell_cnt_q + 3'd1;
    end
  end

  assign rsp_cells = cells_q;
`endif

endmodule
`default_nettype wire
